// File: rtl/bus_slave_resp_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_slave_resp_ctrl_if
//   Bundles the bus-side signals of the slave response controller: the
//   master strobe, decoder chip selects, slave read data/ready, and the
//   registered response returned to the master.
//
//   Signals (active-low names end in '_'):
//     m_as_      master address strobe, one-cycle pulse
//     s_cs_      per-slave chip selects from the address decoder
//     s_rd_data  packed slave read data, slave i at [i*DATA_W +: DATA_W]
//     s_rdy_     per-slave ready
//     m_rd_data  registered read data to the master
//     m_rdy_     registered ready pulse to the master
//     m_err      error qualifier, meaningful only while m_rdy_ is low
//     busy       high while an access is outstanding
//
//   Modports:
//     slave   - the controller side (consumes strobe/selects, drives response)
//     master  - the environment side (drives strobe/selects, observes response)
// -----------------------------------------------------------------------------
interface bus_slave_resp_ctrl_if #(
   parameter int NUM_SLAVES = 8,
   parameter int DATA_W     = 32
);
   logic                         m_as_;
   logic [NUM_SLAVES-1:0]        s_cs_;
   logic [NUM_SLAVES*DATA_W-1:0] s_rd_data;
   logic [NUM_SLAVES-1:0]        s_rdy_;
   logic [DATA_W-1:0]            m_rd_data;
   logic                         m_rdy_;
   logic                         m_err;
   logic                         busy;

   modport slave (
      input  m_as_, s_cs_, s_rd_data, s_rdy_,
      output m_rd_data, m_rdy_, m_err, busy
   );

   modport master (
      output m_as_, s_cs_, s_rd_data, s_rdy_,
      input  m_rd_data, m_rdy_, m_err, busy
   );
endinterface

// File: rtl/bus_slave_resp_ctrl.sv
// -----------------------------------------------------------------------------
// bus_slave_resp_ctrl
//   Registered read-back path between the address decoder and the bus master.
//   On a master strobe it latches the highest-priority selected slave (lowest
//   index), waits for that slave's ready, and returns its read data as a
//   one-cycle registered response. A strobe with no slave selected returns a
//   decode error; a slave that stays not-ready for TIMEOUT wait cycles is
//   terminated with a timeout error.
//
//   Ports:
//     clk    clock
//     reset  synchronous active-high reset, aborts any outstanding access
//     bus    bus_slave_resp_ctrl_if.slave (strobe, selects, slave data/ready,
//            registered response m_rd_data/m_rdy_/m_err, busy)
//
//   Parameters:
//     NUM_SLAVES  number of slave ports (>=1), index 0 highest priority
//     DATA_W      read data width
//     TIMEOUT     wait cycles allowed before a timeout error (>=1)
// -----------------------------------------------------------------------------
module bus_slave_resp_ctrl #(
   parameter int NUM_SLAVES = 8,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   bus_slave_resp_ctrl_if.slave   bus
);

   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            r_state;
   logic [SEL_W-1:0]  r_sel;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rdy_n;
   logic              r_err;
   logic              r_busy;

   logic              w_any_cs;
   logic [SEL_W-1:0]  w_pe_sel;
   logic [SEL_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_slv_data;
   logic              w_slv_rdy;

   assign w_any_cs = ~(&bus.s_cs_);

   // Priority encoder: scanning downward leaves the lowest asserted index.
   always_comb begin
      w_pe_sel = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (!bus.s_cs_[i]) begin
            w_pe_sel = SEL_W'(i);
         end
      end
   end

   // In IDLE the slave is chosen live from the decoder; afterwards the
   // latched selection is used so decoder changes during WAIT are ignored.
   assign w_idx = (r_state == ST_IDLE) ? w_pe_sel : r_sel;

   always_comb begin
      w_slv_data = '0;
      w_slv_rdy  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (w_idx == SEL_W'(i)) begin
            w_slv_data = bus.s_rd_data[i*DATA_W +: DATA_W];
            w_slv_rdy  = ~bus.s_rdy_[i];
         end
      end
   end

   // Response registers are loaded on the transition into RESP, so the
   // response is visible for exactly the one cycle spent in RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_rd_data <= '0;
         r_rdy_n   <= 1'b1;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt     <= '0;
               r_rd_data <= '0;
               r_rdy_n   <= 1'b1;
               r_err     <= 1'b0;
               r_busy    <= 1'b0;
               if (!bus.m_as_) begin
                  if (!w_any_cs) begin
                     r_state <= ST_RESP;
                     r_rdy_n <= 1'b0;
                     r_err   <= 1'b1;
                  end else begin
                     r_sel <= w_pe_sel;
                     if (w_slv_rdy) begin
                        r_state   <= ST_RESP;
                        r_rdy_n   <= 1'b0;
                        r_rd_data <= w_slv_data;
                     end else begin
                        r_state <= ST_WAIT;
                        r_busy  <= 1'b1;
                     end
                  end
               end
            end

            ST_WAIT: begin
               // Ready is tested first so it wins over a same-cycle timeout.
               if (w_slv_rdy) begin
                  r_state   <= ST_RESP;
                  r_rdy_n   <= 1'b0;
                  r_err     <= 1'b0;
                  r_rd_data <= w_slv_data;
                  r_busy    <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= ST_RESP;
                  r_rdy_n   <= 1'b0;
                  r_err     <= 1'b1;
                  r_rd_data <= '0;
                  r_busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            ST_RESP: begin
               r_state   <= ST_IDLE;
               r_cnt     <= '0;
               r_rd_data <= '0;
               r_rdy_n   <= 1'b1;
               r_err     <= 1'b0;
               r_busy    <= 1'b0;
            end

            default: begin
               r_state   <= ST_IDLE;
               r_cnt     <= '0;
               r_rd_data <= '0;
               r_rdy_n   <= 1'b1;
               r_err     <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m_rd_data = r_rd_data;
   assign bus.m_rdy_    = r_rdy_n;
   assign bus.m_err     = r_err;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_bus_slave_resp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_resp_ctrl
//   Scoreboard bench for bus_slave_resp_ctrl. The stimulus process issues
//   accesses and pushes the expected response (data, error, cycle it must
//   appear in) into a queue; a monitor process compares every response the
//   DUT presents against the head of that queue.
// -----------------------------------------------------------------------------
module tb_bus_slave_resp_ctrl;

   localparam int NS = 8;
   localparam int DW = 32;
   localparam int TO = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int            cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [DW-1:0] slv[NS];

   bus_slave_resp_ctrl_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus ();

   bus_slave_resp_ctrl #(
      .NUM_SLAVES (NS),
      .DATA_W     (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, req);
      end
   endtask

   task automatic pack_data();
      for (int i = 0; i < NS; i++) bus.s_rd_data[i*DW +: DW] = slv[i];
   endtask

   // Monitor: every low m_rdy_ must match the oldest expected response;
   // between responses the data/error outputs must be quiet.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.m_rdy_ === 1'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", {31'd0, bus.m_rdy_}, 32'd1);
            end else begin
               mon_e = sb.pop_front();
               chk("resp_cycle", cyc, mon_e.cyc);
               chk("resp_data", bus.m_rd_data, mon_e.data);
               chk("resp_err", {31'd0, bus.m_err}, {31'd0, mon_e.err});
            end
         end else begin
            chk("idle_err", {31'd0, bus.m_err}, 32'd0);
            chk("idle_data", bus.m_rd_data, 32'd0);
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
               chk("resp_missing", {31'd0, bus.m_rdy_}, 32'd0);
               sb.delete(0);
            end
         end
      end
   end

   // Reference model: from the strobe pattern and the wait cycle k in which
   // the selected slave first reports ready (0 = same cycle, >TO = never),
   // derive latency, error and data directly from the protocol rules.
   task automatic do_txn(input logic [NS-1:0] cs, input int k,
                         input logic [DW-1:0] dsel, input bit scr);
      int            sel;
      int            lat;
      bit            derr;
      exp_t          e;
      logic [NS-1:0] rdy;
      derr = (cs == {NS{1'b1}});
      sel  = 0;
      for (int i = NS - 1; i >= 0; i--) if (!cs[i]) sel = i;
      if (derr || k == 0) lat = 1;
      else if (k <= TO)   lat = 1 + k;
      else                lat = TO + 1;
      for (int i = 0; i < NS; i++) slv[i] = $urandom;
      slv[sel] = dsel;
      pack_data();
      e.err  = derr || (k > TO);
      e.data = e.err ? '0 : dsel;
      e.cyc  = cyc + lat;
      sb.push_back(e);

      bus.m_as_ = 1'b0;
      bus.s_cs_ = cs;
      rdy = NS'($urandom);
      if (!derr) rdy[sel] = (k != 0);
      bus.s_rdy_ = rdy;
      @(negedge clk);
      chk("busy_strobe", {31'd0, bus.busy}, 32'd0);

      for (int j = 1; j <= lat; j++) begin
         @(posedge clk); #1;
         bus.m_as_ = scr ? 1'($urandom) : 1'b1;
         if (scr) begin
            bus.s_cs_ = NS'($urandom);
            for (int i = 0; i < NS; i++) if (i != sel) slv[i] = $urandom;
            pack_data();
         end
         rdy = NS'($urandom);
         if (!derr) rdy[sel] = (j != k);
         bus.s_rdy_ = rdy;
         @(negedge clk);
         chk("busy_cycle", {31'd0, bus.busy}, (j < lat) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      bus.m_as_  = 1'b1;
      bus.s_cs_  = {NS{1'b1}};
      bus.s_rdy_ = {NS{1'b1}};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [NS-1:0] cs;
      reset         = 1'b1;
      bus.m_as_     = 1'b1;
      bus.s_cs_     = {NS{1'b1}};
      bus.s_rdy_    = {NS{1'b1}};
      bus.s_rd_data = '0;

      // Reset values
      idle(3);
      @(negedge clk);
      chk("rst_rdy", {31'd0, bus.m_rdy_}, 32'd1);
      chk("rst_err", {31'd0, bus.m_err}, 32'd0);
      chk("rst_data", bus.m_rd_data, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      // Reset held three cycles in the middle of WAIT aborts the access
      bus.m_as_ = 1'b0;
      bus.s_cs_ = ~NS'(8'h08);
      idle(1);
      bus.m_as_ = 1'b1;
      idle(1);
      @(negedge clk);
      chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_rdy", {31'd0, bus.m_rdy_}, 32'd1);
      chk("abort_err", {31'd0, bus.m_err}, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      idle(TO + 4);

      // Zero-wait access to slave 2
      do_txn(~NS'(8'h04), 0, 32'hDEADBEEF, 1'b0);
      idle(1);
      // Slaves 1 and 5 selected, slave 1 ready after 3 wait cycles, selects churn
      do_txn(~NS'(8'h22), 3, 32'h1234_5678, 1'b1);
      idle(1);
      // Decode error
      do_txn({NS{1'b1}}, 0, 32'hFFFF_FFFF, 1'b0);
      // Timeout: selected slave never ready
      do_txn(~NS'(8'h40), TO + 1, 32'hCAFE_F00D, 1'b0);
      // Ready in the last wait cycle beats the timeout
      do_txn(~NS'(8'h80), TO, 32'hA5A5_5A5A, 1'b0);
      // Back-to-back with ignored strobes during WAIT/RESP
      do_txn(~NS'(8'h01), 2, 32'h0BAD_F00D, 1'b1);

      for (int t = 0; t < 300; t++) begin
         cs = ($urandom_range(0, 5) == 0) ? {NS{1'b1}} : NS'($urandom);
         do_txn(cs, int'($urandom_range(0, TO + 2)), $urandom, 1'($urandom));
         idle(int'($urandom_range(0, 2)));
      end

      idle(TO + 4);
      chk("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
